// File: rtl/instr_store_ind_pkg.sv
// instr_store_ind_pkg: shared state encoding, size constants and lane helpers for the store unit.
package instr_store_ind_pkg;
  typedef enum logic [1:0] {IDLE, WR1, WR2} state_e;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  // Helpers work on the widest legal bus (4 lanes, 32 bits); callers truncate to their width.
  function automatic logic [3:0] lane_mask(input logic size, input logic [1:0] k, input logic phase,
                                           input logic [2:0] nb);
    logic [3:0] ones;
    ones = 4'((5'd1 << nb) - 5'd1);
    if (size == SIZE_BYTE) return 4'(5'd1 << (nb - 3'd1 - {1'b0, k}));
    return phase ? 4'(ones << (nb - {1'b0, k})) & ones : ones >> k;
  endfunction
  function automatic logic [31:0] lane_data(input logic size, input logic [1:0] k, input logic phase,
                                            input logic [2:0] nb, input logic [31:0] d);
    if (size == SIZE_BYTE) return {4{d[7:0]}};
    return phase ? d << {nb - {1'b0, k}, 3'b000} : d >> {k, 3'b000};
  endfunction
endpackage

// File: rtl/instr_store_ind_lane_align.sv
// store_lane_align: lane mask and aligned write data for one access of a (possibly split) store.
module store_lane_align
  import instr_store_ind_pkg::*;
#(
  parameter int DATA_W = 16,
  localparam int NB = DATA_W / 8,
  localparam int KW = $clog2(NB)
) (
  input  logic              size,
  input  logic [KW-1:0]     k,
  input  logic              phase,
  input  logic [DATA_W-1:0] regbus1,
  output logic [NB-1:0]     req,
  output logic [DATA_W-1:0] data
);
  always_comb begin
    req = NB'(lane_mask(size, 2'(k), phase, 3'(NB)));
    data = DATA_W'(lane_data(size, 2'(k), phase, 3'(NB), 32'(regbus1)));
  end
endmodule

// File: rtl/instr_store_ind.sv
// instr_store_ind: indexed store unit issuing one or two big-endian lane-masked memory writes per command.
module instr_store_ind
  import instr_store_ind_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int TIMEOUT = 255,
  localparam int NB = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              size,
  input  logic              post_inc,
  input  logic [ADDR_W-1:0] operand,
  input  logic [ADDR_W-1:0] regbus2,
  input  logic [DATA_W-1:0] regbus1,
  output logic [ADDR_W-1:0] memory_address,
  output logic [DATA_W-1:0] memory_data,
  output logic [NB-1:0]     memory_request,
  input  logic              memory_done,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr
);
  localparam int KW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 2);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] sum_q, sum_d, addr_q, addr_d, wb_addr_q, wb_addr_d, sum_in, cur_sum;
  logic [DATA_W-1:0] data_q, data_d, mdata_q, mdata_d, cur_data, align_data;
  logic [NB-1:0] req_q, req_d, align_req;
  logic size_q, size_d, post_inc_q, post_inc_d, busy_q, busy_d, done_q, done_d;
  logic error_q, error_d, wb_valid_q, wb_valid_d, cur_size, ack, tmo;
  store_lane_align #(.DATA_W(DATA_W)) u_align (
    .size    (cur_size),
    .k       (cur_sum[KW-1:0]),
    .phase   (state_q == WR1),
    .regbus1 (cur_data),
    .req     (align_req),
    .data    (align_data)
  );
  always_comb begin
    sum_in = regbus2 + operand;
    cur_sum = (state_q == IDLE) ? sum_in : sum_q;
    cur_size = (state_q == IDLE) ? size : size_q;
    cur_data = (state_q == IDLE) ? regbus1 : data_q;
    // The first cycle of each access is never acknowledged: cnt_q is still zero there.
    ack = (state_q != IDLE) && (cnt_q != '0) && memory_done;
    tmo = (state_q != IDLE) && (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));
    state_d = state_q;
    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    sum_d = sum_q;
    size_d = size_q;
    post_inc_d = post_inc_q;
    data_d = data_q;
    addr_d = addr_q;
    mdata_d = mdata_q;
    req_d = req_q;
    wb_addr_d = wb_addr_q;
    done_d = 1'b0;
    error_d = 1'b0;
    wb_valid_d = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (start) begin
        state_d = WR1;
        sum_d = sum_in;
        size_d = size;
        post_inc_d = post_inc;
        data_d = regbus1;
        addr_d = sum_in;
        mdata_d = align_data;
        req_d = align_req;
      end
    end else if (ack && state_q == WR1 && size_q == SIZE_WORD && sum_q[KW-1:0] != '0) begin
      state_d = WR2;
      cnt_d = '0;
      addr_d = {sum_q[ADDR_W-1:KW], {KW{1'b0}}} + ADDR_W'(NB);
      mdata_d = align_data;
      req_d = align_req;
    end else if (ack || tmo) begin
      state_d = IDLE;
      cnt_d = '0;
      addr_d = '0;
      mdata_d = '0;
      req_d = '0;
      done_d = 1'b1;
      error_d = !ack;
      wb_valid_d = ack && post_inc_q;
      wb_addr_d = (ack && post_inc_q) ? sum_q + (size_q ? ADDR_W'(NB) : ADDR_W'(1)) : wb_addr_q;
    end
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sum_q <= '0;
      size_q <= 1'b0;
      post_inc_q <= 1'b0;
      data_q <= '0;
      addr_q <= '0;
      mdata_q <= '0;
      req_q <= '0;
      wb_addr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      wb_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      size_q <= size_d;
      post_inc_q <= post_inc_d;
      data_q <= data_d;
      addr_q <= addr_d;
      mdata_q <= mdata_d;
      req_q <= req_d;
      wb_addr_q <= wb_addr_d;
      busy_q <= busy_d;
      done_q <= done_d;
      error_q <= error_d;
      wb_valid_q <= wb_valid_d;
    end
  end
  assign memory_address = addr_q;
  assign memory_data = mdata_q;
  assign memory_request = req_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = error_q;
  assign wb_valid = wb_valid_q;
  assign wb_addr = wb_addr_q;
endmodule
